// File: rtl/fwd_pkg.sv
// Shared encodings for the EX-stage operand forwarding controller.
package fwd_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/fwd_sel_calc.sv
// Forwarding select for one source register against the EX/MEM shadow stages.
module fwd_sel_calc #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              ex_valid,
  input  logic              ex_wr,
  input  logic              ex_ld,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_valid,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_dst,
  output logic [1:0]        sel
);
  import fwd_pkg::*;

  logic ex_hit;
  logic mem_hit;

  // A load still in EX cannot forward yet; the hazard logic stalls instead.
  assign ex_hit  = ex_valid && ex_wr && !ex_ld && (ex_dst != '0) && (ex_dst == src);
  assign mem_hit = mem_valid && mem_wr && (mem_dst != '0) && (mem_dst == src);

  always_comb begin
    sel = FWD_REG;
    if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select generation with load-use stall sequencing
// and a saturating stall counter.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_flush,
  input  logic              ext_stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic [CNT_W-1:0]  stall_count
);
  // state    | meaning
  // ST_RUN   | normal flow; load-use hazards are detected here
  // ST_STALL | bubble issued; load now in MEM, consumer re-evaluates in ID
  import fwd_pkg::*;

  fsm_state_t state, state_d;

  logic              ex_valid, ex_wr, ex_ld;
  logic [REG_AW-1:0] ex_dst;
  logic              mem_valid, mem_wr;
  logic [REG_AW-1:0] mem_dst;

  logic       hazard;
  logic       id_ok;
  logic [1:0] sel_a, sel_b;

  assign hazard = id_valid && !id_flush && ex_valid && ex_wr && ex_ld &&
                  (ex_dst != '0) && ((ex_dst == id_rs) || (ex_dst == id_rt));

  assign id_ok = id_valid && !id_flush && !bubble_ex;

  fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_a (
    .src       (id_rs),
    .ex_valid  (ex_valid),
    .ex_wr     (ex_wr),
    .ex_ld     (ex_ld),
    .ex_dst    (ex_dst),
    .mem_valid (mem_valid),
    .mem_wr    (mem_wr),
    .mem_dst   (mem_dst),
    .sel       (sel_a)
  );

  fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_b (
    .src       (id_rt),
    .ex_valid  (ex_valid),
    .ex_wr     (ex_wr),
    .ex_ld     (ex_ld),
    .ex_dst    (ex_dst),
    .mem_valid (mem_valid),
    .mem_wr    (mem_wr),
    .mem_dst   (mem_dst),
    .sel       (sel_b)
  );

  // Stall/bubble are gated by rst_n so they read 0 while reset is held.
  always_comb begin
    state_d     = state;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    if (rst_n) begin
      if (ext_stall) begin
        stall_if_id = 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            if (hazard) begin
              stall_if_id = 1'b1;
              bubble_ex   = 1'b1;
              state_d     = ST_STALL;
            end
          end
          ST_STALL: state_d = ST_RUN;
          default:  state_d = ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (!ext_stall) begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_dst    <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_dst   <= '0;
      fwd_a_sel <= FWD_REG;
      fwd_b_sel <= FWD_REG;
    end else if (!ext_stall) begin
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_dst   <= ex_dst;
      if (id_ok) begin
        ex_valid  <= 1'b1;
        ex_wr     <= id_reg_write;
        ex_ld     <= id_mem_read;
        ex_dst    <= id_dst;
        fwd_a_sel <= sel_a;
        fwd_b_sel <= sel_b;
      end else begin
        ex_valid  <= 1'b0;
        ex_wr     <= 1'b0;
        ex_ld     <= 1'b0;
        ex_dst    <= '0;
        fwd_a_sel <= FWD_REG;
        fwd_b_sel <= FWD_REG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (bubble_ex && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed vector bench for fwd_hazard_ctrl, plus reset-mid-stall sequence.
module tb_fwd_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_reg_write, id_mem_read, id_flush, ext_stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_if_id, bubble_ex;
  logic [31:0] stall_count;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic        stall_s, bubble_s;
  logic [1:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  fwd_hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_flush     (id_flush),
    .ext_stall    (ext_stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_if_id  (stall_if_id),
    .bubble_ex    (bubble_ex),
    .stall_count  (stall_count)
  );

  // Narrow counter copy to reach saturation in a few stalls.
  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_flush     (id_flush),
    .ext_stall    (ext_stall),
    .fwd_a_sel    (fwd_a_s),
    .fwd_b_sel    (fwd_b_s),
    .stall_if_id  (stall_s),
    .bubble_ex    (bubble_s),
    .stall_count  (cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, dst;
    logic       wr, ld, fl, xs;
    logic       st, bb;
    logic [1:0] a, b;
    int         cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input int v, input int rs, input int rt, input int dst,
                              input int wr, input int ld, input int fl, input int xs,
                              input int st, input int bb, input int a, input int b,
                              input int cnt);
    vec_t r;
    r.v   = (v != 0);
    r.rs  = 5'(rs);
    r.rt  = 5'(rt);
    r.dst = 5'(dst);
    r.wr  = (wr != 0);
    r.ld  = (ld != 0);
    r.fl  = (fl != 0);
    r.xs  = (xs != 0);
    r.st  = (st != 0);
    r.bb  = (bb != 0);
    r.a   = 2'(a);
    r.b   = 2'(b);
    r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int v, input int rs, input int rt, input int dst,
                       input int wr, input int ld, input int fl, input int xs);
    id_valid     = (v != 0);
    id_rs        = 5'(rs);
    id_rt        = 5'(rt);
    id_dst       = 5'(dst);
    id_reg_write = (wr != 0);
    id_mem_read  = (ld != 0);
    id_flush     = (fl != 0);
    ext_stall    = (xs != 0);
  endtask

  initial begin
    //            v rs rt dst wr ld fl xs  st bb  a b  cnt
    tv.push_back(mk(1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // add $3
    tv.push_back(mk(1, 3, 4, 5, 1, 0, 0, 0, 0, 0, 2, 0, 0)); // sub $5,$3,$4
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // add $3
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // nop
    tv.push_back(mk(1, 2, 3, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0)); // or $6,$2,$3
    tv.push_back(mk(1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // add $3
    tv.push_back(mk(1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 2, 0, 0)); // addi $3,$3
    tv.push_back(mk(1, 3, 3, 7, 1, 0, 0, 0, 0, 0, 2, 2, 0)); // newest wins
    tv.push_back(mk(1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // add $0
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // read $0
    tv.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // lw $0
    tv.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // no stall
    tv.push_back(mk(1, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // lw $3
    tv.push_back(mk(1, 3, 3, 4, 1, 0, 0, 0, 1, 1, 0, 0, 1)); // add $4,$3,$3
    tv.push_back(mk(1, 3, 3, 4, 1, 0, 0, 0, 0, 0, 1, 1, 1));
    tv.push_back(mk(1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1)); // lw $5
    tv.push_back(mk(1, 5, 5, 6, 1, 0, 1, 0, 0, 0, 0, 0, 1)); // flushed use
    tv.push_back(mk(1, 6, 5, 7, 1, 0, 0, 0, 0, 0, 0, 1, 1)); // EX cleared
    tv.push_back(mk(1, 7, 0, 2, 1, 1, 0, 0, 0, 0, 2, 0, 1)); // lw $2,($7)
    tv.push_back(mk(1, 2, 1,10, 1, 0, 0, 1, 1, 0, 2, 0, 1)); // frozen x3
    tv.push_back(mk(1, 2, 1,10, 1, 0, 0, 1, 1, 0, 2, 0, 1));
    tv.push_back(mk(1, 2, 1,10, 1, 0, 0, 1, 1, 0, 2, 0, 1));
    tv.push_back(mk(1, 2, 1,10, 1, 0, 0, 0, 1, 1, 0, 0, 2));
    tv.push_back(mk(1, 2, 1,10, 1, 0, 0, 0, 0, 0, 1, 0, 2));
    tv.push_back(mk(1,10, 0, 4, 1, 1, 0, 0, 0, 0, 2, 0, 2)); // lw $4,($10)
    tv.push_back(mk(1, 4, 0, 5, 1, 1, 0, 0, 1, 1, 0, 0, 3)); // lw $5,($4)
    tv.push_back(mk(1, 4, 0, 5, 1, 1, 0, 0, 0, 0, 1, 0, 3));
    tv.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 1, 1, 0, 0, 4)); // second stall
    tv.push_back(mk(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 1, 0, 4));

    rst_n = 1'b0;
    drive(1, 3, 3, 4, 1, 0, 0, 1);
    repeat (2) @(posedge clk);
    #2;
    chk("reset stall_if_id", {31'b0, stall_if_id}, 32'd0);
    chk("reset bubble_ex", {31'b0, bubble_ex}, 32'd0);
    chk("reset fwd_a", {30'b0, fwd_a_sel}, 32'd0);
    chk("reset fwd_b", {30'b0, fwd_b_sel}, 32'd0);
    chk("reset count", stall_count, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(int'(tv[i].v), int'(tv[i].rs), int'(tv[i].rt), int'(tv[i].dst),
            int'(tv[i].wr), int'(tv[i].ld), int'(tv[i].fl), int'(tv[i].xs));
      #2;
      chk($sformatf("v%0d stall_if_id", i), {31'b0, stall_if_id}, {31'b0, tv[i].st});
      chk($sformatf("v%0d bubble_ex", i), {31'b0, bubble_ex}, {31'b0, tv[i].bb});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d fwd_a", i), {30'b0, fwd_a_sel}, {30'b0, tv[i].a});
      chk($sformatf("v%0d fwd_b", i), {30'b0, fwd_b_sel}, {30'b0, tv[i].b});
      chk($sformatf("v%0d count", i), stall_count, 32'(tv[i].cnt));
      chk($sformatf("v%0d sat count", i), {30'b0, cnt_s},
          32'((tv[i].cnt > 3) ? 3 : tv[i].cnt));
    end

    // Reset asserted while the FSM sits in STALL.
    drive(1, 1, 0, 8, 1, 1, 0, 0);                 // lw $8
    @(posedge clk);
    #1;
    drive(1, 8, 8, 9, 1, 0, 0, 0);                 // use of $8
    #2;
    chk("pre-reset stall_if_id", {31'b0, stall_if_id}, 32'd1);
    @(posedge clk);
    #1;
    chk("pre-reset count", stall_count, 32'd5);
    ext_stall = 1'b1;
    #1;
    chk("pre-reset ext stall", {31'b0, stall_if_id}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-stall reset stall_if_id", {31'b0, stall_if_id}, 32'd0);
    chk("mid-stall reset bubble_ex", {31'b0, bubble_ex}, 32'd0);
    chk("mid-stall reset fwd_a", {30'b0, fwd_a_sel}, 32'd0);
    chk("mid-stall reset fwd_b", {30'b0, fwd_b_sel}, 32'd0);
    chk("mid-stall reset count", stall_count, 32'd0);
    chk("mid-stall reset sat count", {30'b0, cnt_s}, 32'd0);
    @(posedge clk);
    #2;
    ext_stall = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post-reset no stall", {31'b0, stall_if_id}, 32'd0);
    @(posedge clk);
    #1;
    chk("post-reset fwd_a", {30'b0, fwd_a_sel}, 32'd0);
    chk("post-reset count", stall_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
